hamming_secded_decoder: RTL
===========================

Name: hamming_secded_decoder

Overview:
Program-2 counterpart of the Hamming SECDED encoder flow. On a start pulse, the block walks NUM_MSG 16-bit codewords stored as byte pairs in data memory. For each codeword it computes the syndrome and overall parity, corrects single-bit errors and flags double-bit errors. It writes the recovered 11-bit message plus 2 status flags back to memory as byte pairs. It sits beside the data memory in top_level and owns the memory port while busy.

Parameters:
NUM_MSG, 15, number of codewords processed per run
SRC_BASE, 30, byte address of the first codeword LSB; codeword i occupies SRC_BASE+2i (low byte) and SRC_BASE+2i+1 (high byte)
DST_BASE, 0, byte address of the first result LSB; result i occupies DST_BASE+2i (low byte) and DST_BASE+2i+1 (high byte)
AW, 8, memory byte-address width

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request pulse; sampled only in IDLE
done  output  1  run complete; stays high until the next accepted start or reset
mem_addr  output  AW  byte address for read or write
mem_rd_data  input  8  memory read data; combinational, valid in the same cycle as mem_addr
mem_wr_en  output  1  write strobe; memory writes on the rising edge
mem_wr_data  output  8  write data
single_cnt  output  $clog2(NUM_MSG+1)  count of corrected codewords (see Optional Feature)
double_cnt  output  $clog2(NUM_MSG+1)  count of double-error codewords (see Optional Feature)

Behaviour:
- Reset values: state=IDLE, msg index=0, done=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, counters=0. Asserting reset mid-run aborts immediately; no further writes occur; bytes already written stay in memory.
- Codeword layout (cw[15:0]):
  - cw[15:9]=d11..d5, cw[8]=p8, cw[7:5]=d4..d2, cw[4]=p4, cw[3]=d1, cw[2]=p2, cw[1]=p1, cw[0]=p0.
  - Bit index k (1..15) equals the Hamming position.
- Syndrome bit sN = XOR of cw[k] over k in 1..15 where (k & N) != 0, for N in {8,4,2,1}. Syndrome s = {s8,s4,s2,s1}. Overall parity P = XOR of cw[15:0].
- Classification:
  - s=0, P=0: no error; flags=00.
  - P=1: single error. Flip cw[s]; s=0 means p0 flipped and data is unchanged. flags=01.
  - s!=0, P=0: double error. Data is extracted uncorrected. flags=10.
  - Flags 11 never occurs.
- Result bytes:
  - low = {d8..d1}
  - high = {flags[1:0], 3'b000, d11, d10, d9}
- FSM states, one cycle each: IDLE -> RD_LO -> RD_HI -> DECODE -> WR_LO -> WR_HI -> (RD_LO for the next message | DONE).
  - RD_LO: latch low byte from SRC_BASE+2i.
  - RD_HI: latch high byte from SRC_BASE+2i+1.
  - DECODE: register the corrected data and flags.
  - WR_LO: mem_wr_en=1, addr DST_BASE+2i.
  - WR_HI: mem_wr_en=1, addr DST_BASE+2i+1; increment i.
  - DONE: done=1; return to IDLE at the next cycle, with done held high.
- mem_wr_en is high only in WR_LO and WR_HI. mem_addr in IDLE/DONE holds 0.
- Latency: 5 cycles per message. done rises on the 5*NUM_MSG-th rising edge after the edge that samples start (75 for defaults).
- A start pulse while not in IDLE is ignored. start accepted from IDLE with done=1 clears done on that same edge.
- The index counter wraps to 0 when the run ends. The address arithmetic is modulo 2^AW.

Optional Feature:
HAMMING_STATS_EN
- Defined: single_cnt and double_cnt increment in DECODE for flags 01 and 10 respectively. They clear on reset and on accepted start, and hold their values after done.
- Undefined: both outputs are tied to 0 and the counter logic is absent. All other behaviour is identical.

Test Plan:
- Data 0, clean: cw 0x0000 at addr 30/31 -> writes low 0x00, high 0x00; done after 75 edges with defaults.
- cw 0xFFFF (data 0x7FF, clean) -> low 0xFF, high 0x07. Same with cw 0xFFFE (p0 flipped) -> low 0xFF, high 0x47.
- cw 0x0020 (data 0, bit5 flipped; s=5, P=1) -> low 0x00, high 0x40. cw 0x0208 (bits 3 and 9 flipped; s=10, P=0) -> low 0x11, high 0x80.
- 15 random 11-bit messages, each encoded and given 0, 1 or 2 random flips -> all 30 result bytes match the model. With HAMMING_STATS_EN, counters equal the model counts.
- start pulsed again at cycle 20 of a run -> ignored; output and timing unchanged. Second start after done -> done drops on the accept edge and the run repeats.
- reset asserted during WR_HI of message 3 -> done=0 and mem_wr_en=0 immediately; no writes follow; a subsequent start reprocesses from message 0.

Source files
------------

// File: rtl/hamming_secded_decoder.sv
// Hamming SECDED decoder: walks NUM_MSG codewords in data memory, corrects/flags errors, writes results back.
// Optional per-run error counters are enabled by defining HAMMING_STATS_EN.
module hamming_secded_decoder #(
    parameter int NUM_MSG  = 15,
    parameter int SRC_BASE = 30,
    parameter int DST_BASE = 0,
    parameter int AW       = 8,
    localparam int CW      = $clog2(NUM_MSG + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rd_data,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data,
    output logic [CW-1:0] single_cnt,
    output logic [CW-1:0] double_cnt
);

    localparam int IW = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;

    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, DECODE, WR_LO, WR_HI, DONE} state_t;

    state_t          state, next_state;
    logic [IW-1:0]   idx;
    logic [7:0]      cw_lo, cw_hi;
    logic [7:0]      res_lo, res_hi;
    logic            done_q;
    logic            last;
    logic [AW-1:0]   src_addr, dst_addr;

    logic [15:0]     cw, fixed;
    logic [3:0]      syn;
    logic            par;
    logic [1:0]      flags;
    logic [10:0]     data;

    assign last     = (idx == IW'(NUM_MSG - 1));
    assign src_addr = AW'(SRC_BASE) + (AW'(idx) << 1);
    assign dst_addr = AW'(DST_BASE) + (AW'(idx) << 1);
    assign done     = done_q;

    // The syndrome equals the XOR of the positions of all set bits in cw[15:1].
    always_comb begin
        cw  = {cw_hi, cw_lo};
        syn = '0;
        for (int k = 1; k < 16; k++) begin
            if (cw[k]) syn = syn ^ 4'(k);
        end
        par   = ^cw;
        fixed = cw;
        if (par) fixed[syn] = ~cw[syn];
        if (par)             flags = 2'b01;
        else if (syn != '0)  flags = 2'b10;
        else                 flags = 2'b00;
        data = {fixed[15:9], fixed[7:5], fixed[3]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state  = state;
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        unique case (state)
            IDLE:    if (start) next_state = RD_LO;
            RD_LO: begin
                mem_addr   = src_addr;
                next_state = RD_HI;
            end
            RD_HI: begin
                mem_addr   = src_addr + AW'(1);
                next_state = DECODE;
            end
            DECODE:  next_state = WR_LO;
            WR_LO: begin
                mem_wr_en   = 1'b1;
                mem_addr    = dst_addr;
                mem_wr_data = res_lo;
                next_state  = WR_HI;
            end
            WR_HI: begin
                mem_wr_en   = 1'b1;
                mem_addr    = dst_addr + AW'(1);
                mem_wr_data = res_hi;
                next_state  = last ? DONE : RD_LO;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // done is set on the way into DONE and only cleared by reset or an accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx    <= '0;
            cw_lo  <= '0;
            cw_hi  <= '0;
            res_lo <= '0;
            res_hi <= '0;
            done_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    idx    <= '0;
                    done_q <= 1'b0;
                end
                RD_LO:  cw_lo <= mem_rd_data;
                RD_HI:  cw_hi <= mem_rd_data;
                DECODE: begin
                    res_lo <= data[7:0];
                    res_hi <= {flags, 3'b000, data[10:8]};
                end
                WR_HI: begin
                    if (last) begin
                        idx    <= '0;
                        done_q <= 1'b1;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef HAMMING_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            single_cnt <= '0;
            double_cnt <= '0;
        end else if (state == IDLE && start) begin
            single_cnt <= '0;
            double_cnt <= '0;
        end else if (state == DECODE) begin
            if (flags == 2'b01) single_cnt <= single_cnt + CW'(1);
            if (flags == 2'b10) double_cnt <= double_cnt + CW'(1);
        end
    end
`else
    assign single_cnt = '0;
    assign double_cnt = '0;
`endif

endmodule
